idli_uart_m: RTL

//  8N1 UART peripheral attached to the core's nibble-serial data path.
//  - TX: takes a 16-bit word as four 4-bit slices (ctr 0..3) and transmits its low byte on o_uart_tx.
//  - RX: receives bytes on i_uart_rx into a one-entry buffer, read back by the core as four slices.
//  - Instantiated in idli_top_m; drives o_top_uart_tx, samples i_top_uart_rx.

---
 rtl/idli_uart_m_if.sv | 24 ++
 rtl/idli_uart_m.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_uart_m_if.sv
// Core-side bus of the UART peripheral: slice counter, TX write and RX read
// handshakes, and the status flags the core polls.
//   master : core side (drives ctr, requests and write slices)
//   slave  : UART side (drives read slices and status flags)
interface idli_uart_m_if;
  logic [1:0] i_uart_ctr;      // slice counter; slice n is on the bus when ctr==n
  logic       i_uart_tx_en;    // TX write request, sampled at ctr==0
  logic [3:0] i_uart_slice;    // TX write data slice, LSB slice first
  logic       o_uart_tx_full;  // TX holding buffer occupied
  logic       i_uart_rx_en;    // RX read request, sampled at ctr==0
  logic [3:0] o_uart_slice;    // RX read data slice
  logic       o_uart_rx_vld;   // RX buffer holds an unread byte
  logic       o_uart_rx_err;   // sticky framing/overrun error

  modport master (
    output i_uart_ctr, i_uart_tx_en, i_uart_slice, i_uart_rx_en,
    input  o_uart_tx_full, o_uart_slice, o_uart_rx_vld, o_uart_rx_err
  );

  modport slave (
    input  i_uart_ctr, i_uart_tx_en, i_uart_slice, i_uart_rx_en,
    output o_uart_tx_full, o_uart_slice, o_uart_rx_vld, o_uart_rx_err
  );
endinterface

// File: rtl/idli_uart_m.sv
// 8N1 UART peripheral on the core's nibble-serial data path.
//   TX: a 4-slice write delivers a 16-bit word; its low byte is framed onto
//       o_uart_tx through a one-entry holding buffer (double-buffered).
//   RX: frames from i_uart_rx land in a one-entry buffer read as 4 slices.
// Ports:
//   i_top_gck   core clock
//   i_top_rst_n async active-low reset
//   bus         core-side bus (idli_uart_m_if.slave)
//   i_uart_rx   asynchronous serial input
//   o_uart_tx   serial output, idle high
module idli_uart_m #(
  parameter int unsigned CLK_PER_BIT = 16
) (
  input  logic           i_top_gck,
  input  logic           i_top_rst_n,
  idli_uart_m_if.slave   bus,
  input  logic           i_uart_rx,
  output logic           o_uart_tx
);

  localparam int unsigned     CW        = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic ctr0, ctr1, ctr3;
  assign ctr0 = (bus.i_uart_ctr == 2'd0);
  assign ctr1 = (bus.i_uart_ctr == 2'd1);
  assign ctr3 = (bus.i_uart_ctr == 2'd3);

  // ---------------- TX write path ----------------
  logic       wr_q;
  logic [7:0] tx_buf_q;
  logic       tx_full_q;
  logic       tx_set;

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      wr_q     <= 1'b0;
      tx_buf_q <= '0;
    end else begin
      if (ctr0 && bus.i_uart_tx_en && !tx_full_q) begin
        wr_q          <= 1'b1;
        tx_buf_q[3:0] <= bus.i_uart_slice;
      end else if (wr_q && ctr1) begin
        tx_buf_q[7:4] <= bus.i_uart_slice;
      end
      if (wr_q && ctr3) wr_q <= 1'b0;
    end
  end

  assign tx_set = wr_q && ctr3;

  // ---------------- TX FSM ----------------
  state_t        tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic          tx_q;
  logic          tx_load;

  // A full buffer is taken either from idle or on the last stop-bit cycle,
  // so consecutive frames abut. A write can only complete while the buffer
  // is empty, so tx_set and tx_load never coincide.
  assign tx_load = tx_full_q &&
                   ((tx_state_q == ST_IDLE) ||
                    (tx_state_q == ST_STOP && tx_cnt_q == BIT_LAST));

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      tx_full_q  <= 1'b0;
    end else if (tx_load) begin
      tx_sh_q    <= tx_buf_q;
      tx_full_q  <= 1'b0;
      tx_state_q <= ST_START;
      tx_cnt_q   <= '0;
      tx_q       <= 1'b0;
    end else begin
      if (tx_set) tx_full_q <= 1'b1;
      case (tx_state_q)
        ST_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= ST_DATA;
            tx_q       <= tx_sh_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= ST_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_q     <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= ST_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_uart_tx          = tx_q;
  assign bus.o_uart_tx_full = tx_full_q;

  // ---------------- RX input path ----------------
  logic [1:0] sync_q;
  logic       rx_prev_q;
  logic       rx_s;
  logic       rx_fall;

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], i_uart_rx};
      rx_prev_q <= sync_q[1];
    end
  end

  assign rx_s    = sync_q[1];
  assign rx_fall = rx_prev_q && !rx_s;

  // ---------------- RX FSM ----------------
  state_t        rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_stop_smp, rx_push, rx_ferr;

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      case (rx_state_q)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= ST_START;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
          end
        end
        ST_START: begin
          // Mid-bit check of the start bit; high means a glitch.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          // Leaves at mid stop bit so an immediately following start edge is seen.
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= ST_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_stop_smp = (rx_state_q == ST_STOP) && (rx_cnt_q == BIT_LAST);
  assign rx_push     = rx_stop_smp && rx_s;
  assign rx_ferr     = rx_stop_smp && !rx_s;

  // ---------------- RX buffer and read ----------------
  logic       rd_q;
  logic       rx_vld_q, rx_err_q;
  logic [7:0] rx_byte_q;
  logic       rx_pop, rd_act;

  assign rx_pop = rd_q && ctr3;

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      rd_q      <= 1'b0;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      if (ctr0 && bus.i_uart_rx_en) rd_q <= 1'b1;
      else if (ctr3)                rd_q <= 1'b0;

      // A pop in the same cycle frees the entry for the incoming byte.
      if (rx_push && (!rx_vld_q || rx_pop)) begin
        rx_byte_q <= rx_sh_q;
        rx_vld_q  <= 1'b1;
      end else if (rx_pop) begin
        rx_vld_q <= 1'b0;
      end

      // Setting has priority over the read clear.
      if (rx_ferr || (rx_push && rx_vld_q && !rx_pop)) rx_err_q <= 1'b1;
      else if (rx_pop)                                  rx_err_q <= 1'b0;
    end
  end

  // The read is live combinationally in its ctr==0 cycle, before rd_q rises.
  assign rd_act = rd_q || (ctr0 && bus.i_uart_rx_en);

  always_comb begin
    bus.o_uart_slice = '0;
    if (rd_act && rx_vld_q) begin
      case (bus.i_uart_ctr)
        2'd0:    bus.o_uart_slice = rx_byte_q[3:0];
        2'd1:    bus.o_uart_slice = rx_byte_q[7:4];
        default: bus.o_uart_slice = '0;
      endcase
    end
  end

  assign bus.o_uart_rx_vld = rx_vld_q;
  assign bus.o_uart_rx_err = rx_err_q;

endmodule
